// File: rtl/count_report_pkg.sv
`default_nettype none
// ============================================================================
// Module   : count_report_pkg
// Purpose  : Shared types, constants and helpers for the counter UART
//            reporter: FSM state type, frame length, count ceiling, ASCII
//            codes, one double-dabble iteration and the frame byte selector.
// Revision : 1.0 - initial release
// ============================================================================
package count_report_pkg;

    // Report controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVERT = 3'd1,
        ST_SEND    = 3'd2,
        ST_NEXT    = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    localparam int          FRAME_LEN = 7;
    localparam logic [13:0] MAX_COUNT = 14'd9999;

    // Binary-to-BCD working register: 16 BCD bits above 14 binary bits
    localparam int DD_STEPS = 14;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_U  = 8'h55;
    localparam logic [7:0] ASCII_D  = 8'h44;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
    function automatic logic [29:0] dd_step(input logic [29:0] v);
        logic [29:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[14 + 4*i +: 4] >= 4'd5) begin
                t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[28:0], 1'b0};
    endfunction

    // Byte `sel` of the report frame: mode, four digits, status, line feed
    function automatic logic [7:0] frame_byte(input logic [2:0]  sel,
                                              input logic        m,
                                              input logic        r,
                                              input logic [15:0] bcd);
        logic [7:0] b;
        case (sel)
            3'd0:    b = m ? ASCII_U : ASCII_D;
            3'd1:    b = ASCII_0 + {4'd0, bcd[15:12]};
            3'd2:    b = ASCII_0 + {4'd0, bcd[11:8]};
            3'd3:    b = ASCII_0 + {4'd0, bcd[7:4]};
            3'd4:    b = ASCII_0 + {4'd0, bcd[3:0]};
            3'd5:    b = r ? ASCII_R : ASCII_S;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_byte
// Purpose  : 8N1 UART byte serialiser with its own baud counter. A start
//            request is taken only while idle; byte_done pulses during the
//            last cycle of the stop bit so a follow-on byte can be started
//            in the very next cycle. tx is registered (one cycle behind the
//            internal bit timing) so the line never glitches.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int BAUD_DIV = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int                CNT_W     = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]        LAST_BIT  = 4'd9;

    logic             active_q,   active_d;
    logic [9:0]       shreg_q,    shreg_d;
    logic [3:0]       bit_idx_q,  bit_idx_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic             tx_q,       tx_d;

    // Bit sequencing: load {stop, data, start}, shift out LSB first
    always_comb begin
        active_d   = active_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q;
        byte_done  = 1'b0;
        if (!active_q) begin
            if (start) begin
                active_d   = 1'b1;
                shreg_d    = {1'b1, data, 1'b0};
                bit_idx_d  = 4'd0;
                baud_cnt_d = '0;
            end
        end else if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_d = '0;
            if (bit_idx_q == LAST_BIT) begin
                active_d  = 1'b0;
                byte_done = 1'b1;
            end else begin
                bit_idx_d = bit_idx_q + 4'd1;
                shreg_d   = {1'b1, shreg_q[9:1]};
            end
        end else begin
            baud_cnt_d = baud_cnt_q + 1'b1;
        end
        tx_d = active_q ? shreg_q[0] : 1'b1;
    end

    // Serialiser state registers; line idles high out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q   <= 1'b0;
            shreg_q    <= '1;
            bit_idx_q  <= '0;
            baud_cnt_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            active_q   <= active_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            tx_q       <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = active_q;

endmodule
`default_nettype wire

// File: rtl/count_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module   : count_uart_reporter
// Purpose  : Captures the counter value, direction and run status on request,
//            converts the count (clamped to 9999) to four decimal digits with
//            a sequential double-dabble, and sends the 7-byte frame
//            "<U|D>dddd<R|S>\n" as 8N1 UART on tx.
// Options  : COUNT_REPORT_AUTO_EN - when defined, any change of count, mode
//            or run, or a request arriving while busy, raises a pending flag
//            that starts a (coalesced) report on the next idle cycle.
// Revision : 1.0 - initial release
// ============================================================================
module count_uart_reporter
    import count_report_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] count,
    input  logic        mode,
    input  logic        run,
    input  logic        send_req,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int         BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);
    localparam logic [3:0] DD_LAST  = 4'(DD_STEPS - 1);

    state_t      state_q,    state_d;
    logic [2:0]  idx_q,      idx_d;
    logic [3:0]  dd_cnt_q,   dd_cnt_d;
    logic [29:0] dd_q,       dd_d;
    logic        mode_cap_q, mode_cap_d;
    logic        run_cap_q,  run_cap_d;

    logic [13:0] count_clamped;
    logic        req;
    logic        accept;
    logic        tx_start;
    logic [2:0]  byte_sel;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        byte_done;

    assign count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;
    assign accept        = (state_q == ST_IDLE) && req;
    assign busy          = (state_q == ST_CONVERT) || (state_q == ST_SEND) ||
                           (state_q == ST_NEXT);
    assign done          = (state_q == ST_FINISH);

`ifdef COUNT_REPORT_AUTO_EN
    logic [13:0] count_prev_q;
    logic        mode_prev_q;
    logic        run_prev_q;
    logic        pending_q, pending_d;
    logic        inputs_changed;

    // Pending request: set by input changes or a request during a frame
    always_comb begin
        inputs_changed = (count != count_prev_q) || (mode != mode_prev_q) ||
                         (run != run_prev_q);
        pending_d = pending_q;
        if (inputs_changed || (send_req && busy)) begin
            pending_d = 1'b1;
        end
        if (accept) begin
            pending_d = 1'b0;
        end
    end

    // Previous-cycle input copies and the pending flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_prev_q <= '0;
            mode_prev_q  <= 1'b0;
            run_prev_q   <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            count_prev_q <= count;
            mode_prev_q  <= mode;
            run_prev_q   <= run;
            pending_q    <= pending_d;
        end
    end

    assign req = send_req | pending_q;
`else
    assign req = send_req;
`endif

    // Report sequencing: capture, convert, then walk the frame byte by byte.
    // NEXT launches the following byte itself so only one idle bit-cycle
    // separates consecutive bytes on the line.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dd_cnt_d   = dd_cnt_q;
        dd_d       = dd_q;
        mode_cap_d = mode_cap_q;
        run_cap_d  = run_cap_q;
        tx_start   = 1'b0;
        byte_sel   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_CONVERT;
                    dd_d       = {16'd0, count_clamped};
                    dd_cnt_d   = '0;
                    idx_d      = '0;
                    mode_cap_d = mode;
                    run_cap_d  = run;
                end
            end
            ST_CONVERT: begin
                dd_d = dd_step(dd_q);
                if (dd_cnt_q == DD_LAST) begin
                    dd_cnt_d = '0;
                    state_d  = ST_SEND;
                end else begin
                    dd_cnt_d = dd_cnt_q + 4'd1;
                end
            end
            ST_SEND: begin
                tx_start = !tx_busy;
                if (byte_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d    = idx_q + 3'd1;
                    byte_sel = idx_q + 3'd1;
                    tx_start = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers; reset aborts any frame in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            dd_cnt_q   <= '0;
            dd_q       <= '0;
            mode_cap_q <= 1'b0;
            run_cap_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dd_cnt_q   <= dd_cnt_d;
            dd_q       <= dd_d;
            mode_cap_q <= mode_cap_d;
            run_cap_q  <= run_cap_d;
        end
    end

    assign tx_data = frame_byte(byte_sel, mode_cap_q, run_cap_q, dd_q[29:14]);

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk       (clk),
        .reset     (reset),
        .start     (tx_start),
        .data      (tx_data),
        .tx        (tx),
        .busy      (tx_busy),
        .byte_done (byte_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_count_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_uart_reporter
// Purpose  : Self-checking bench for count_uart_reporter (BAUD_DIV = 10).
//            Decodes tx bit-by-bit and compares whole frames with a
//            behavioural frame model and a directed vector table.
// Options  : COUNT_REPORT_AUTO_EN selects the change-triggered sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_uart_reporter;

    localparam int CLK_FREQ  = 1000;
    localparam int BAUD_RATE = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] count;
    logic        mode;
    logic        run;
    logic        send_req;
    logic        tx;
    logic        busy;
    logic        done;

    int  cyc      = 0;
    int  done_cnt = 0;
    int  n_pass   = 0;
    int  n_total  = 0;
    time edges_t[$];

    count_uart_reporter #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .count    (count),
        .mode     (mode),
        .run      (run),
        .send_req (send_req),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) done_cnt <= done_cnt + (done === 1'b1 ? 1 : 0);
    always @(tx) edges_t.push_back($time);

    typedef struct {
        logic [13:0] cnt;
        logic        md;
        logic        rn;
        logic [55:0] exp;
        int          inj;
    } vec_t;

    // Frame derived directly from the report rules with integer arithmetic
    function automatic logic [55:0] model_frame(input int c, input logic m, input logic r);
        int v;
        v = (c > 9999) ? 9999 : c;
        return {(m ? 8'h55 : 8'h44), 8'(48 + v / 1000), 8'(48 + (v / 100) % 10),
                8'(48 + (v / 10) % 10), 8'(48 + v % 10), (r ? 8'h52 : 8'h53), 8'h0A};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Receive one 8N1 byte, sampling each bit at its centre
    task automatic recv_byte(output logic [7:0] b, output int fall_cyc, output bit ok);
        int n;
        bit start_ok;
        n = 0; b = '0; ok = 1'b0; fall_cyc = 0;
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) return;
        fall_cyc = cyc;
        repeat (5) @(negedge clk);
        start_ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = tx;
        end
        repeat (10) @(negedge clk);
        ok = start_ok && (tx === 1'b1);
    endtask

    task automatic start_req(input logic [13:0] c, input logic m, input logic r, output int acc);
        @(negedge clk);
        count = c; mode = m; run = r; send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
        acc = cyc;
        check("busy_after_accept", 64'(busy), 64'd1);
    endtask

    // inj: 1 = request + count change mid-frame, 2 = step count twice
    // mid-frame, 3 = request during the done cycle
    task automatic collect(input string tag, input logic [55:0] exp, input int acc,
                           input bit chk_lat, input int inj, input bit chk_width);
        logic [55:0] got;
        logic [7:0]  b;
        int          f, f0, base, d0, n;
        int          dif[9];
        bit          ok, all_ok;
        base = edges_t.size(); d0 = done_cnt; all_ok = 1'b1; got = '0; f0 = 0;
        for (int i = 0; i < 7; i++) begin
            recv_byte(b, f, ok);
            if (i == 0) f0 = f;
            all_ok = all_ok && ok;
            got = {got[47:0], b};
            if (inj == 1 && i == 1) begin
                @(negedge clk); send_req = 1'b1; count = ~count;
                @(negedge clk); send_req = 1'b0;
            end
            if (inj == 2 && i == 1) begin
                @(negedge clk); count = count + 14'd1;
                repeat (3) @(negedge clk);
                count = count + 14'd1;
            end
        end
        check({tag, "_framing"}, 64'(all_ok), 64'd1);
        check({tag, "_frame"}, 64'(got), 64'(exp));
        if (chk_lat) check({tag, "_latency"}, 64'(f0 - acc), 64'd16);
        if (chk_width) begin
            for (int k = 0; k < 9; k++)
                dif[k] = (base + k + 1 < edges_t.size()) ?
                         int'((edges_t[base + k + 1] - edges_t[base + k]) / 10) : 0;
            check({tag, "_bit_width"},
                  {8'(dif[0]), 8'(dif[1]), 8'(dif[2]), 8'(dif[3]), 8'(dif[4]),
                   8'(dif[6]), 8'(dif[7]), 8'(dif[8])},
                  {8'd30, 8'd10, 8'd30, 8'd10, 8'd10, 8'd50, 8'd20, 8'd20});
            check({tag, "_byte_gap"}, 64'(dif[5] >= 10 && dif[5] <= 11), 64'd1);
        end
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        if (inj == 3) send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
        check({tag, "_done_pulse"}, {31'd0, done, 32'(done_cnt - d0)}, {32'd0, 32'd1});
    endtask

    task automatic no_frame(input string tag);
        int base, d0;
        base = edges_t.size(); d0 = done_cnt;
        repeat (300) @(negedge clk);
        check(tag, {32'(edges_t.size() - base), 32'(done_cnt - d0)}, 64'd0);
    endtask

    initial begin
        vec_t        vecs[5];
        int          acc, f, base;
        logic [7:0]  b;
        bit          ok;
        logic [13:0] c;
        logic        m, r;
        int          n;

        vecs[0] = '{14'd1234,  1'b1, 1'b1, "U1234R\n", 0};
        vecs[1] = '{14'd12000, 1'b0, 1'b0, "D9999S\n", 0};
        vecs[2] = '{14'd0,     1'b0, 1'b1, "D0000R\n", 0};
        vecs[3] = '{14'd777,   1'b1, 1'b0, "U0777S\n", 1};
        vecs[4] = '{14'd16383, 1'b1, 1'b1, "U9999R\n", 0};

        reset = 1'b0; send_req = 1'b0; count = '0; mode = 1'b0; run = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 64'(tx), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

`ifndef COUNT_REPORT_AUTO_EN
        for (int i = 0; i < 5; i++) begin
            start_req(vecs[i].cnt, vecs[i].md, vecs[i].rn, acc);
            collect($sformatf("vec%0d", i), vecs[i].exp, acc, 1'b1, vecs[i].inj,
                    vecs[i].cnt == 14'd0);
            if (vecs[i].inj == 1) no_frame($sformatf("vec%0d_req_ignored", i));
        end

        start_req(14'd42, 1'b0, 1'b1, acc);
        collect("finish_req", model_frame(42, 1'b0, 1'b1), acc, 1'b1, 3, 1'b0);
        no_frame("finish_req_ignored");

        for (int i = 0; i < 4; i++) begin
            c = 14'($urandom_range(0, 16383));
            m = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            start_req(c, m, r, acc);
            collect($sformatf("rand%0d", i), model_frame(int'(c), m, r), acc, 1'b1, 0, 1'b0);
        end

        // Reset during the fourth byte, while a 0 data bit is on the line
        start_req(14'd321, 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) recv_byte(b, f, ok);
        n = 0;
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (35) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_tx", 64'(tx), 64'd1);
        check("rst_mid_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        base = edges_t.size();
        repeat (120) @(negedge clk);
        check("rst_no_partial", 64'(edges_t.size() - base), 64'd0);
        start_req(14'd5678, 1'b0, 1'b1, acc);
        collect("after_rst", model_frame(5678, 1'b0, 1'b1), acc, 1'b1, 0, 1'b0);
`else
        start_req(14'd5, 1'b1, 1'b1, acc);
        collect("auto_first", model_frame(5, 1'b1, 1'b1), acc, 1'b1, 2, 1'b0);
        collect("auto_follow", model_frame(7, 1'b1, 1'b1), 0, 1'b0, 0, 1'b0);
        no_frame("auto_quiet");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_uart_reporter.md
Name: count_uart_reporter

Overview:
- Transmit side of the counter's UART link: the inbound byte path carries commands into the up/down counter, and this block sends the counter state back to the host.
- On request, it latches the 14-bit count plus mode and run/stop status, converts the count to 4 ASCII decimal digits and serialises a 7-byte frame as 8N1 UART on `tx`.
- Sits beside the counter and FND controller in the counter top level; its inputs are the counter's outputs.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate; BAUD_DIV = CLK_FREQ/BAUD_RATE clock cycles per bit (integer; must be >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- count  input  14  current counter value.
- mode  input  1  counter direction, 1 = up, 0 = down.
- run  input  1  1 = running, 0 = stopped.
- send_req  input  1  single-cycle report request.
- tx  output  1  UART serial line, idles high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, busy=0, done=0.
  - FSM returns to IDLE; baud counter and byte index cleared.
  - A reset mid-frame aborts the frame immediately; no partial byte is completed.
- Frame format, 7 bytes in order:
  - Byte 0: mode character, 'U' (0x55) if mode=1, 'D' (0x44) if mode=0.
  - Bytes 1-4: thousands, hundreds, tens, ones, each as ASCII ('0'+digit).
  - Byte 5: 'R' (0x52) if run=1, 'S' (0x53) if run=0.
  - Byte 6: LF (0x0A).
- Capture and clamping:
  - count, mode and run are captured in the accept cycle; later input changes do not affect the frame in flight.
  - count > 9999 is clamped to 9999 before conversion.
- FSM states: IDLE -> CONVERT -> SEND -> NEXT -> (SEND | FINISH) -> IDLE.
  - IDLE: send_req=1 at a clock edge is accepted; busy=1 from the next cycle.
  - CONVERT: sequential binary-to-BCD (double-dabble), exactly 14 cycles.
  - SEND: sub-module transmits the current byte.
  - NEXT: increments byte index; returns to SEND if bytes remain, else goes to FINISH.
  - FINISH: done=1 for one cycle, busy=0 in that same cycle, then IDLE.
- Byte timing:
  - Start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly BAUD_DIV cycles.
  - The baud counter restarts at every start bit.
  - At most 1 idle-high clock cycle between consecutive bytes (the NEXT state).
- Latency: the first start bit begins 16 cycles after the accept edge (1 to enter CONVERT, 14 to convert, 1 to load).
- send_req while busy=1 is ignored, not queued (unless the optional feature is enabled).
- send_req asserted in the FINISH cycle is ignored; it is accepted only in IDLE.

Optional Feature:
- Macro: COUNT_REPORT_AUTO_EN.
- Defined:
  - Any change of count, mode or run (compared with its value on the previous clock) sets a pending flag, as does send_req arriving while busy.
  - The pending flag is accepted as a request on the first IDLE cycle and cleared on acceptance.
  - Values are captured at acceptance, so the frame carries the latest state; multiple changes coalesce into one frame.
- Undefined: only send_req in IDLE starts a frame; no change detection logic is present.

Decomposition:
- Package count_report_pkg:
  - State enum type.
  - FRAME_LEN = 7 and MAX_COUNT = 9999.
  - ASCII constants: ASCII_0, ASCII_U, ASCII_D, ASCII_R, ASCII_S, ASCII_LF.
- Sub-module uart_tx_byte: 8N1 serialiser with internal baud counter.
  - Handshake: start/data[7:0] in; tx and a one-cycle byte_done out.
  - start is honoured only when it is idle.
  - Reusable elsewhere in the codebase.

Test Plan (CLK_FREQ=1000, BAUD_RATE=100, so BAUD_DIV=10):
- Report 1234: count=1234, mode=1, run=1, one-cycle send_req.
  - tx must decode to 0x55 0x31 0x32 0x33 0x34 0x52 0x0A.
  - Start bit falls 16 cycles after the accept edge.
  - done pulses once; busy is high from the accept+1 edge until the done cycle.
- Clamping and alternate status: count=12000, mode=0, run=0 -> frame "D9999S\n".
- Busy and capture behaviour: send_req again while busy -> no second frame (macro undefined). Change count during the frame -> transmitted digits unchanged.
- Zero value: count=0 -> digits "0000"; each bit lasts exactly 10 cycles, measured on tx edges.
- Reset mid-frame: assert reset during byte 3 -> tx=1 and busy=0 asynchronously. After release, a new send_req yields a complete, correct frame.
- With COUNT_REPORT_AUTO_EN defined:
  - Step count 5 -> 6 -> 7 during one frame -> exactly one follow-up frame, carrying 7.
  - Hold inputs constant -> no further frames.
